pid_delta: RTL and testbench

Incremental PID increment generator. Computes the signed control increment d_uk from a setpoint/feedback pair, using one shared multiplier over a multi-cycle sequence. It sits upstream of the PID output accumulator: its `d_uk` output feeds the accumulator's increment input directly, and `d_uk_valid` qualifies each new increment.

---
 rtl/pid_delta.sv | 176 +++++++++++++++++
 tb/tb_pid_delta.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pid_delta.sv
// Incremental PID increment generator: one shared multiplier, six-state sequence per sample.
// Define PID_DELTA_SAT_EN to clamp the result to OUT_W bits instead of wrapping.
module pid_delta #(
  parameter int DATA_W = 12,
  parameter int K_W    = 8,
  parameter int FRAC   = 4,
  parameter int OUT_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] feedback,
  input  logic [K_W-1:0]    kp,
  input  logic [K_W-1:0]    ki,
  input  logic [K_W-1:0]    kd,
  input  logic              hist_clr,
  output logic [OUT_W-1:0]  d_uk,
  output logic              d_uk_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int E_W   = DATA_W + 1;
  localparam int D_W   = DATA_W + 3;
  localparam int G_W   = K_W + 1;
  localparam int P_W   = D_W + G_W;
  localparam int ACC_W = DATA_W + K_W + 5;

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_P, S_I, S_D, S_OUT} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       sp_q, sp_d, fb_q, fb_d;
  logic [K_W-1:0]          kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [E_W-1:0]   e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [D_W-1:0]   dp_q, dp_d, di_q, di_d, dd_q, dd_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        d_uk_q, d_uk_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;

  logic signed [E_W-1:0]   e0_c;
  logic signed [D_W-1:0]   e0_x, e1_x, e2_x, mul_a;
  logic signed [G_W-1:0]   mul_b;
  logic signed [P_W-1:0]   prod;
  logic [OUT_W-1:0]        res;

`ifdef PID_DELTA_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_W-1:0] acc_sh;
`endif

  always_comb begin
    e0_c = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
    e0_x = D_W'(e0_c);
    e1_x = D_W'(e1_q);
    e2_x = D_W'(e2_q);
    // Single multiplier: the state selects which difference/gain pair feeds it.
    mul_a = dd_q;
    mul_b = $signed({1'b0, kd_q});
    case (state_q)
      S_P:     begin mul_a = dp_q; mul_b = $signed({1'b0, kp_q}); end
      S_I:     begin mul_a = di_q; mul_b = $signed({1'b0, ki_q}); end
      default: ;
    endcase
    prod = P_W'(mul_a) * P_W'(mul_b);
`ifdef PID_DELTA_SAT_EN
    acc_sh = acc_q >>> FRAC;
    if (acc_sh > SAT_MAX)      res = SAT_MAX[OUT_W-1:0];
    else if (acc_sh < SAT_MIN) res = SAT_MIN[OUT_W-1:0];
    else                       res = acc_sh[OUT_W-1:0];
`else
    res = OUT_W'(acc_q >>> FRAC);
`endif
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    fb_d      = fb_q;
    kp_d      = kp_q;
    ki_d      = ki_q;
    kd_d      = kd_q;
    e0_d      = e0_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    dp_d      = dp_q;
    di_d      = di_q;
    dd_d      = dd_q;
    acc_d     = acc_q;
    d_uk_d    = d_uk_q;
    valid_d   = 1'b0;
    overrun_d = sample_valid && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (sample_valid) begin
        sp_d    = setpoint;
        fb_d    = feedback;
        kp_d    = kp;
        ki_d    = ki;
        kd_d    = kd;
        state_d = S_ERR;
      end
      S_ERR: begin
        e0_d    = e0_c;
        dp_d    = e0_x - e1_x;
        di_d    = e0_x;
        dd_d    = e0_x - (e1_x <<< 1) + e2_x;
        state_d = S_P;
      end
      S_P: begin acc_d = ACC_W'(prod);         state_d = S_I;   end
      S_I: begin acc_d = acc_q + ACC_W'(prod); state_d = S_D;   end
      S_D: begin acc_d = acc_q + ACC_W'(prod); state_d = S_OUT; end
      S_OUT: begin
        d_uk_d  = res;
        valid_d = 1'b1;
        e2_d    = e1_q;
        e1_d    = e0_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Clear wins over everything, including a result that would land this cycle.
    if (hist_clr) begin
      state_d   = S_IDLE;
      e1_d      = '0;
      e2_d      = '0;
      d_uk_d    = d_uk_q;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sp_q      <= '0;
      fb_q      <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      e0_q      <= '0;
      e1_q      <= '0;
      e2_q      <= '0;
      dp_q      <= '0;
      di_q      <= '0;
      dd_q      <= '0;
      acc_q     <= '0;
      d_uk_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      fb_q      <= fb_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
      kd_q      <= kd_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      dp_q      <= dp_d;
      di_q      <= di_d;
      dd_q      <= dd_d;
      acc_q     <= acc_d;
      d_uk_q    <= d_uk_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign d_uk       = d_uk_q;
  assign d_uk_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pid_delta.sv
// Bench for pid_delta: hand-computed vector table through a scoreboard, plus overrun/abort sequences.
module tb_pid_delta;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] setpoint = '0, feedback = '0;
  logic [7:0]  kp = '0, ki = '0, kd = '0;
  logic        hist_clr = 1'b0;
  logic [14:0] d_uk;
  logic        d_uk_valid, busy, overrun;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cnt = 0;
  int exp_q[$];

  pid_delta #(.DATA_W(12), .K_W(8), .FRAC(4), .OUT_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .setpoint(setpoint), .feedback(feedback), .kp(kp), .ki(ki), .kd(kd),
    .hist_clr(hist_clr), .d_uk(d_uk), .d_uk_valid(d_uk_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit clr;
    int sp, fb, kp, ki, kd;
    int exp_wrap, exp_sat;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard: each d_uk_valid pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && d_uk_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got d_uk=%0d, expected no result", $signed(d_uk));
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'($signed(d_uk)) != e) begin
          miscompares++;
          $display("FAIL d_uk: got %0d, expected %0d", $signed(d_uk), e);
        end
      end
    end
  end

  always @(negedge clk) if (overrun) ovr_cnt++;

  task automatic pulse_clr();
    @(negedge clk) hist_clr = 1'b1;
    @(negedge clk) hist_clr = 1'b0;
  endtask

  task automatic accept(input int s, input int f, input int p, input int i, input int d);
    @(negedge clk);
    setpoint = 12'(s); feedback = 12'(f); kp = 8'(p); ki = 8'(i); kd = 8'(d);
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (d_uk_valid) begin found = 1'b1; break; end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    if (v.clr) pulse_clr();
`ifdef PID_DELTA_SAT_EN
    exp_q.push_back(v.exp_sat);
`else
    exp_q.push_back(v.exp_wrap);
`endif
    accept(v.sp, v.fb, v.kp, v.ki, v.kd);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (d_uk_valid) begin lat = k; break; end
    end
    chk("valid_latency", lat, 5);
    chk("busy_after_result", int'(busy), 0);
  endtask

  vec_t vt[7];
  bit   found;
  int   ovr0;

  initial begin
    // History carries from row to row unless clr is set.
    vt[0] = '{0, 100,   90,  16,  16,   0,     20,     20};
    vt[1] = '{0, 100,   95,  16,  16,  16,    -15,    -15};
    vt[2] = '{1,   0,    1,   1,   0,   0,     -1,     -1};
    vt[3] = '{1, 4095,   0, 255, 255,   0,   -544,  16383};
    vt[4] = '{0, 2000, 2100, 32,   8,   4, -10513, -10513};
    vt[5] = '{0,  50,   50,   0,   0, 255,   2915,  16383};
    vt[6] = '{0,   0, 4095, 255, 255, 255,   -778, -16384};

    repeat (3) @(negedge clk);
    chk("rst_d_uk", int'(d_uk), 0);
    chk("rst_valid", int'(d_uk_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i]);

    // Overrun: a second sample while busy is dropped and flagged exactly once.
    pulse_clr();
    ovr0 = ovr_cnt;
    exp_q.push_back(20);
    accept(100, 90, 16, 16, 0);
    @(negedge clk);
    @(negedge clk);
    setpoint = 12'd7; feedback = 12'd3000; kp = 8'd200; ki = 8'd200; kd = 8'd200;
    sample_valid = 1'b1;
    @(negedge clk) sample_valid = 1'b0;
    wait_valid(found);
    chk("overrun_result_seen", int'(found), 1);
    repeat (2) @(negedge clk);
    chk("overrun_pulses", ovr_cnt - ovr0, 1);

    // hist_clr mid-flight together with sample_valid: aborted, no overrun, d_uk holds.
    ovr0 = ovr_cnt;
    accept(200, 0, 255, 255, 255);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    hist_clr = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0; sample_valid = 1'b0;
    chk("clr_busy", int'(busy), 0);
    wait_valid(found);
    chk("clr_no_valid", int'(found), 0);
    chk("clr_d_uk_held", int'($signed(d_uk)), 20);
    chk("clr_no_overrun", ovr_cnt - ovr0, 0);
    run_vec('{0, 100, 90, 16, 16, 0, 20, 20});

    // Asynchronous reset mid-flight.
    accept(100, 95, 16, 16, 16);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_d_uk", int'(d_uk), 0);
    chk("rst_mid_valid", int'(d_uk_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_overrun", int'(overrun), 0);
    @(negedge clk) rst_n = 1'b1;
    wait_valid(found);
    chk("rst_mid_no_valid", int'(found), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
